// File: rtl/inv_subbytes_if.sv
// Valid/ready handshake bundle for the inverse nibble-substitution stage.
// The master side feeds words in and consumes results; the slave side is the stage itself.
interface inv_subbytes_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_subbytes_seq.sv
// S-AES InvSubNibbles stage: one shared bank of NIB_PER_CYC inverse S-box lookups,
// swept MSB nibble first across the 16-bit state, with valid/ready on both sides.
module inv_subbytes_seq #(
    parameter int NIB_PER_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    inv_subbytes_if.slave bus,
    output logic          busy
);

    localparam int         GROUPS   = 4 / NIB_PER_CYC;
    localparam logic [1:0] LAST_CNT = 2'(GROUPS - 1);

    generate
        if (NIB_PER_CYC != 1 && NIB_PER_CYC != 2 && NIB_PER_CYC != 4) begin : g_bad_param
            $error("inv_subbytes_seq: NIB_PER_CYC must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [15:0] work;
    logic [15:0] work_sub;
    logic [15:0] out_data_r;
    logic [1:0]  pos;
    logic        last_grp;

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        case (n)
            4'h0: inv_sbox = 4'hA;
            4'h1: inv_sbox = 4'h5;
            4'h2: inv_sbox = 4'h9;
            4'h3: inv_sbox = 4'hB;
            4'h4: inv_sbox = 4'h1;
            4'h5: inv_sbox = 4'h7;
            4'h6: inv_sbox = 4'h8;
            4'h7: inv_sbox = 4'hF;
            4'h8: inv_sbox = 4'h6;
            4'h9: inv_sbox = 4'h0;
            4'hA: inv_sbox = 4'h2;
            4'hB: inv_sbox = 4'h3;
            4'hC: inv_sbox = 4'hC;
            4'hD: inv_sbox = 4'h4;
            4'hE: inv_sbox = 4'hD;
            default: inv_sbox = 4'hE;
        endcase
    endfunction

    // Nibble p (0 = MSB) lives at bit offset 4*(3-p), i.e. {~p, 2'b00}.
    always_comb begin
        work_sub = work;
        pos      = 2'd0;
        for (int k = 0; k < NIB_PER_CYC; k++) begin
            pos = 2'(int'(cnt) * NIB_PER_CYC + k);
            work_sub[{~pos, 2'b00} +: 4] = inv_sbox(work[{~pos, 2'b00} +: 4]);
        end
    end

    assign last_grp = (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = BUSY;
            BUSY:    if (last_grp)      state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            work       <= 16'h0000;
            out_data_r <= 16'h0000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work <= bus.in_data;
                        cnt  <= 2'd0;
                    end
                end
                BUSY: begin
                    work <= work_sub;
                    cnt  <= cnt + 2'd1;
                    if (last_grp) out_data_r <= work_sub;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_r;
    assign busy          = (state != IDLE);

endmodule
